round_controller: RTL
=====================

Name: round_controller

Overview:
- Match-level FSM that consumes player1_score/player2_score from the score counter and produces the still_graphic freeze and score-clear controls that feed back into it.
- Sequences idle → serve countdown → play → point pause → game over.
- Sits in the logic layer between the score counter, the ball/paddle logic and the drawing stage; all timing runs on the frame-rate timing_tick.

Parameters:
- WIN_SCORE, 9, points needed to win; legal range 1..9, matching the 4-bit score that saturates at 9.
- SERVE_TICKS, 120, timing_tick pulses spent in SERVE_WAIT; legal range 1..255.
- PAUSE_TICKS, 90, timing_tick pulses spent in POINT_PAUSE; legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- timing_tick  in  1  one-clk pulse per frame.
- start_btn  in  1  start button level, already synchronised/debounced.
- player1_score  in  4  current player 1 score (0..9).
- player2_score  in  4  current player 2 score (0..9).
- still_graphic  out  1  1 = freeze ball and clear scored flags.
- score_clr  out  1  one-clk pulse that zeroes the score counter.
- game_over  out  1  high in GAME_OVER.
- winner  out  2  0 = none, 1 = player 1, 2 = player 2.
- serve_dir  out  1  0 = serve toward left pad, 1 = toward right pad.

Behaviour:
- Reset values (asynchronous, immediate on rst=1, including mid-game):
  - state=IDLE, still_graphic=1, score_clr=0, game_over=0, winner=0, serve_dir=0.
  - All counters and edge/prev registers cleared.
- Registers:
  - All outputs are registered.
  - start_prev, p1_prev and p2_prev are updated every clk.
  - start_edge = start_btn & ~start_prev.
- Point detection:
  - p1_pt = (player1_score != p1_prev); p2_pt likewise.
  - Points are acted on only in PLAY.
  - If both change in the same clk, player 1 takes priority and player 2's change is ignored.
- tick_cnt (8 bit):
  - Counts timing_tick pulses only.
  - Cleared on every state entry.
  - The timed exit fires on the tick where tick_cnt == N-1, so a state lasts exactly N ticks.
- IDLE:
  - still_graphic=1.
  - On start_edge: go to SERVE_WAIT, pulse score_clr for 1 clk, serve_dir=0, winner=0.
- SERVE_WAIT:
  - still_graphic=1.
  - After SERVE_TICKS ticks: go to PLAY, with still_graphic=0 from the next clk.
- PLAY:
  - still_graphic=0.
  - On p1_pt: if player1_score >= WIN_SCORE, go to GAME_OVER with winner=1; else go to POINT_PAUSE with serve_dir=1.
  - On p2_pt: same rule with winner=2 and serve_dir=0.
  - still_graphic returns to 1 on the clk edge after the score change becomes visible (1-clk latency).
- POINT_PAUSE:
  - still_graphic=1.
  - After PAUSE_TICKS ticks: go to PLAY.
- GAME_OVER:
  - still_graphic=1, game_over=1; winner is held.
  - On start_edge: go to IDLE with winner=0 and game_over=0. score_clr is not pulsed here (it pulses on the next start).
- start_edge is ignored in SERVE_WAIT, PLAY and POINT_PAUSE. A held start_btn produces only one edge.
- Score changes outside PLAY (e.g. the clear caused by score_clr) are not treated as points.
- timing_tick arriving in the same clk as a transition is consumed by the old state and not counted in the new one.

Decomposition:
- Shared game package (alongside vga_pkg) holds:
  - game_state_t enum {IDLE, SERVE_WAIT, PLAY, POINT_PAUSE, GAME_OVER};
  - MAX_SCORE=9;
  - winner encodings.
- One natural sub-module, tick_timer:
  - Loadable 8-bit timing_tick counter.
  - Inputs: clear, limit. Output: done pulse.
  - Instantiated once and shared by SERVE_WAIT and POINT_PAUSE.

Test Plan:
(Simulation parameters: WIN_SCORE=3, SERVE_TICKS=3, PAUSE_TICKS=2; tick every 10 clk.)
- Reset during PLAY → next sample shows state IDLE, still_graphic=1, game_over=0, winner=0, before any clk edge.
- start_btn 0→1 in IDLE → score_clr high for exactly 1 clk; still_graphic stays 1 for 3 ticks, then 0.
- In PLAY, player1_score 0→1 → still_graphic=1 one clk later, serve_dir=1; still_graphic returns to 0 after 2 ticks.
- Drive player2_score 0→1→2→3 across rallies → after the third point: game_over=1, winner=2, still_graphic=1; a further score change causes no response.
- Both scores change in the same clk (1→2) in PLAY → treated as a player 1 point: serve_dir=1, winner stays 0.
- start_btn held high through GAME_OVER → IDLE exit, no new game until the button is released and pressed again; a press in SERVE_WAIT has no effect.

Source files
------------

// File: rtl/round_controller_pkg.sv
// Shared game definitions for the match-level logic.
//   game_state_t : match phases sequenced by round_controller
//   MAX_SCORE    : ceiling of the 4-bit saturating score counter
//   WINNER_*     : encodings driven on round_controller.winner
//   tick_count_t : width of the frame-tick timer
package round_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_WAIT,
    PLAY,
    POINT_PAUSE,
    GAME_OVER
  } game_state_t;

  localparam int MAX_SCORE = 9;

  localparam logic [1:0] WINNER_NONE = 2'd0;
  localparam logic [1:0] WINNER_P1   = 2'd1;
  localparam logic [1:0] WINNER_P2   = 2'd2;

  typedef logic [7:0] tick_count_t;

endpackage

// File: rtl/round_controller_tick.sv
// tick_timer: counts timing_tick pulses and fires done on the tick that
// completes 'limit' ticks.
//   clk, rst : clock, asynchronous active-high reset
//   tick     : one-clk frame pulse to be counted
//   clear    : holds the count at zero (owner is not in a timed state)
//   limit    : number of ticks the timed state lasts (1..255)
//   done     : combinational pulse on the tick where count == limit-1
module tick_timer
  import round_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        clear,
  input  tick_count_t limit,
  output logic        done
);

  tick_count_t count;

  // Combinational so the owner can leave its state on the same edge that
  // consumes the final tick.
  assign done = tick & ~clear & (count == limit - tick_count_t'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || done) begin
      count <= '0;
    end else if (tick) begin
      count <= count + tick_count_t'(1);
    end
  end

endmodule

// File: rtl/round_controller.sv
// round_controller: match-level FSM (idle -> serve countdown -> play ->
// point pause -> game over) driving the ball freeze and score clear.
//   clk, rst      : clock, asynchronous active-high reset
//   timing_tick   : one-clk pulse per frame, time base of the timed states
//   start_btn     : debounced start button level
//   player1_score : current player 1 score (0..9)
//   player2_score : current player 2 score (0..9)
//   still_graphic : 1 freezes the ball and clears scored flags
//   score_clr     : one-clk pulse zeroing the score counter
//   game_over     : high in GAME_OVER
//   winner        : WINNER_NONE / WINNER_P1 / WINNER_P2
//   serve_dir     : 0 serve toward left pad, 1 toward right pad
module round_controller
  import round_controller_pkg::*;
#(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 120,
  parameter int PAUSE_TICKS = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timing_tick,
  input  logic       start_btn,
  input  logic [3:0] player1_score,
  input  logic [3:0] player2_score,
  output logic       still_graphic,
  output logic       score_clr,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       serve_dir
);

  // A target above the saturating score could never be reached.
  localparam int          WIN_CLAMPED = (WIN_SCORE > MAX_SCORE) ? MAX_SCORE : WIN_SCORE;
  localparam logic [3:0]  win_level   = 4'(WIN_CLAMPED);
  localparam tick_count_t serve_limit = tick_count_t'(SERVE_TICKS);
  localparam tick_count_t pause_limit = tick_count_t'(PAUSE_TICKS);

  game_state_t state;
  logic        start_prev;
  logic [3:0]  p1_prev;
  logic [3:0]  p2_prev;

  logic        start_edge;
  logic        p1_pt;
  logic        p2_pt;
  logic        timer_clear;
  logic        timer_done;
  tick_count_t timer_limit;

  assign start_edge = start_btn & ~start_prev;
  assign p1_pt      = (player1_score != p1_prev);
  assign p2_pt      = (player2_score != p2_prev);

  // The timer only runs in the two timed states; every entry into them comes
  // from an untimed state (count held at zero) or via done (count cleared), so
  // the count always starts at zero and a tick on the transition edge is lost.
  assign timer_clear = (state != SERVE_WAIT) && (state != POINT_PAUSE);
  assign timer_limit = (state == SERVE_WAIT) ? serve_limit : pause_limit;

  tick_timer u_tick_timer (
    .clk   (clk),
    .rst   (rst),
    .tick  (timing_tick),
    .clear (timer_clear),
    .limit (timer_limit),
    .done  (timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      still_graphic <= 1'b1;
      score_clr     <= 1'b0;
      game_over     <= 1'b0;
      winner        <= WINNER_NONE;
      serve_dir     <= 1'b0;
      start_prev    <= 1'b0;
      p1_prev       <= '0;
      p2_prev       <= '0;
    end else begin
      // Edge/change detectors track their inputs every clk, so score changes
      // made outside PLAY (including the clear) never register as points.
      start_prev <= start_btn;
      p1_prev    <= player1_score;
      p2_prev    <= player2_score;
      score_clr  <= 1'b0;

      unique case (state)
        IDLE: begin
          still_graphic <= 1'b1;
          if (start_edge) begin
            state     <= SERVE_WAIT;
            score_clr <= 1'b1;
            serve_dir <= 1'b0;
            winner    <= WINNER_NONE;
          end
        end

        SERVE_WAIT: begin
          if (timer_done) begin
            state         <= PLAY;
            still_graphic <= 1'b0;
          end
        end

        PLAY: begin
          // Player 1 wins ties: a simultaneous player 2 change is dropped.
          if (p1_pt) begin
            still_graphic <= 1'b1;
            if (player1_score >= win_level) begin
              state     <= GAME_OVER;
              game_over <= 1'b1;
              winner    <= WINNER_P1;
            end else begin
              state     <= POINT_PAUSE;
              serve_dir <= 1'b1;
            end
          end else if (p2_pt) begin
            still_graphic <= 1'b1;
            if (player2_score >= win_level) begin
              state     <= GAME_OVER;
              game_over <= 1'b1;
              winner    <= WINNER_P2;
            end else begin
              state     <= POINT_PAUSE;
              serve_dir <= 1'b0;
            end
          end
        end

        POINT_PAUSE: begin
          if (timer_done) begin
            state         <= PLAY;
            still_graphic <= 1'b0;
          end
        end

        GAME_OVER: begin
          // Scores are cleared by the next start from IDLE, not here.
          if (start_edge) begin
            state     <= IDLE;
            game_over <= 1'b0;
            winner    <= WINNER_NONE;
          end
        end

        default: begin
          state         <= IDLE;
          still_graphic <= 1'b1;
        end
      endcase
    end
  end

endmodule
